// File: rtl/branch_redirect_ctrl.sv
// Redirects fetch on taken EX branches/jumps: flushes IF/ID + ID/EX, waits for imem, drains one stale fetch.
// Latency: one cycle from acceptance to pc_sel; new branches are ignored while busy.
module branch_redirect_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        imem_ready,
  input  logic        stall_in,
  input  logic        clr_counts,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        stall_out,
  output logic        busy,
  output logic        misalign_err,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] taken_count_q, taken_count_d;
  logic        misalign_err_q, misalign_err_d;
  logic        pc_sel_q, pc_sel_d;
  logic        flush_ifid_q, flush_ifid_d;
  logic        flush_idex_q, flush_idex_d;
  logic        busy_q, busy_d;

  logic accept;
  logic aligned;
  logic redirect_go;

  always_comb begin
    accept      = (state_q == IDLE) && ex_valid && !stall_in;
    aligned     = (ex_target[1:0] == 2'b00);
    redirect_go = accept && ex_taken && aligned;

    state_d     = state_q;
    pc_target_d = pc_target_q;
    case (state_q)
      IDLE: begin
        if (redirect_go) begin
          state_d     = REDIRECT;
          pc_target_d = ex_target;
        end
      end
      REDIRECT: if (imem_ready) state_d = DRAIN;
      DRAIN:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    misalign_err_d = accept && ex_taken && !aligned;

    // Clear wins over a same-cycle increment; both counters saturate.
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (clr_counts) begin
      branch_count_d = 16'h0000;
      taken_count_d  = 16'h0000;
    end else begin
      if (accept && (branch_count_q != 16'hFFFF)) branch_count_d = branch_count_q + 16'd1;
      if (redirect_go && (taken_count_q != 16'hFFFF)) taken_count_d = taken_count_q + 16'd1;
    end

    // Outputs are registered off the next state so they align with it.
    pc_sel_d     = (state_d == REDIRECT);
    flush_idex_d = (state_d == REDIRECT);
    flush_ifid_d = (state_d != IDLE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_target_q    <= 32'h0;
      branch_count_q <= 16'h0;
      taken_count_q  <= 16'h0;
      misalign_err_q <= 1'b0;
      pc_sel_q       <= 1'b0;
      flush_ifid_q   <= 1'b0;
      flush_idex_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_target_q    <= pc_target_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
      misalign_err_q <= misalign_err_d;
      pc_sel_q       <= pc_sel_d;
      flush_ifid_q   <= flush_ifid_d;
      flush_idex_q   <= flush_idex_d;
      busy_q         <= busy_d;
    end
  end

  // A flush in progress always overrides the hazard unit's stall.
  assign stall_out    = stall_in && !busy_q;
  assign pc_sel       = pc_sel_q;
  assign pc_target    = pc_target_q;
  assign flush_ifid   = flush_ifid_q;
  assign flush_idex   = flush_idex_q;
  assign busy         = busy_q;
  assign misalign_err = misalign_err_q;
  assign branch_count = branch_count_q;
  assign taken_count  = taken_count_q;

endmodule
